// File: rtl/m_lsu_pkg.sv
// rtl/m_lsu_pkg.sv - shared constants and types for the M-stage load/store unit
package m_lsu_pkg;

    localparam int          LSU_TIMEOUT = 16;
    localparam int          LSU_CNT_W   = 5;
    localparam logic [31:0] LSU_DM_TOP  = 32'h0000_2FFF;

    // Timer/IRQ bridge window and its read-only COUNT registers
    localparam logic [31:0] IO_BASE     = 32'h0000_7F00;
    localparam logic [31:0] IO_TOP      = 32'h0000_7F23;
    localparam logic [31:0] TMR0_COUNT  = 32'h0000_7F08;
    localparam logic [31:0] TMR1_COUNT  = 32'h0000_7F18;

    localparam logic [1:0]  ST_IDLE     = 2'd0;
    localparam logic [1:0]  ST_BUSY     = 2'd1;
    localparam logic [1:0]  ST_DONE     = 2'd2;

    localparam logic [4:0]  EXC_NONE    = 5'd0;
    localparam logic [4:0]  EXC_ADEL    = 5'd4;
    localparam logic [4:0]  EXC_ADES    = 5'd5;

    localparam logic [1:0]  SZ_BYTE     = 2'd0;
    localparam logic [1:0]  SZ_HALF     = 2'd1;

    // Everything the load extender needs, latched when the access issues
    typedef struct packed {
        logic [1:0] size;
        logic       sgn;
        logic [1:0] lo;
    } ld_fmt_t;

endpackage

// File: rtl/m_lsu_ext.sv
// rtl/m_lsu_ext.sv - load data lane select and sign/zero extension
module m_lsu_ext
    import m_lsu_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_size,
    input  logic        i_signed,
    input  logic [1:0]  i_lo,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = i_rdata[{i_lo, 3'b000} +: 8];
    assign w_half = i_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

    // Pick the addressed lane and extend; size 2 (and the unused 3) pass the word through
    always_comb begin
        o_data = i_rdata;
        case (i_size)
            SZ_BYTE: o_data = {{24{i_signed & w_byte[7]}}, w_byte};
            SZ_HALF: o_data = {{16{i_signed & w_half[15]}}, w_half};
            default: o_data = i_rdata;
        endcase
    end

endmodule

// File: rtl/m_lsu.sv
// rtl/m_lsu.sv - M-stage load/store unit with bus handshake, stall and address exceptions
module m_lsu
    import m_lsu_pkg::*;
#(
    parameter int          TIMEOUT = LSU_TIMEOUT,
    parameter logic [31:0] DM_TOP  = LSU_DM_TOP,
    parameter int          CNT_W   = LSU_CNT_W
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        M_ld,
    input  logic        M_st,
    input  logic [1:0]  M_size,
    input  logic        M_ld_signed,
    input  logic [31:0] M_addr,
    input  logic [31:0] M_wdata,
    input  logic        M_flush,
    input  logic        M_hold,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ready,
    input  logic [31:0] bus_rdata,
    output logic [31:0] M_DMRD,
    output logic        M_lsu_stall,
    output logic        M_exc,
    output logic [4:0]  M_exc_code
);

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_we;
    logic [31:0]      r_addr;
    logic [3:0]       r_be;
    logic [31:0]      r_wdata;
    logic [31:0]      r_rdata;
    ld_fmt_t          r_fmt;
    logic             r_tmo;

    logic        w_acc;
    logic        w_store;
    logic        w_misalign;
    logic        w_in_dm;
    logic        w_in_io;
    logic        w_fault;
    logic        w_idle;
    logic        w_exc_idle;
    logic        w_issue;
    logic        w_last;
    logic        w_exc_done;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;

    // A load wins if both strobes are ever seen together
    assign w_acc      = M_ld | M_st;
    assign w_store    = M_st & ~M_ld;
    assign w_idle     = (r_state == ST_IDLE);

    // Size 3 is treated like a word so it can never slip through unaligned
    assign w_misalign = ((M_size == SZ_HALF) & M_addr[0]) | (M_size[1] & (|M_addr[1:0]));
    assign w_in_dm    = (M_addr <= DM_TOP);
    assign w_in_io    = (M_addr >= IO_BASE) & (M_addr <= IO_TOP);

    // The bridge only takes whole words, and its COUNT registers are read-only
    assign w_fault    = w_misalign
                      | ~(w_in_dm | w_in_io)
                      | (w_in_io & ~M_size[1])
                      | (w_store & ((M_addr == TMR0_COUNT) | (M_addr == TMR1_COUNT)));

    // The exception is not gated by M_flush: CP0 derives the flush from it
    assign w_exc_idle = w_idle & w_acc & w_fault;
    assign w_issue    = w_idle & w_acc & ~w_fault & ~M_flush;
    assign w_last     = (r_cnt == CNT_W'(TIMEOUT - 1));
    assign w_exc_done = (r_state == ST_DONE) & r_tmo;

    // Store lane steering: replicate the datum across the word, enable only its lanes
    always_comb begin
        w_be    = 4'b1111;
        w_wdata = M_wdata;
        case (M_size)
            SZ_BYTE: begin
                w_be    = 4'b0001 << M_addr[1:0];
                w_wdata = {4{M_wdata[7:0]}};
            end
            SZ_HALF: begin
                w_be    = M_addr[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{M_wdata[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_wdata = M_wdata;
            end
        endcase
    end

    // Access sequencer: issue from IDLE, wait for ready or timeout, report in DONE
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_be    <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_fmt   <= '0;
            r_tmo   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_issue) begin
                        r_state    <= ST_BUSY;
                        r_cnt      <= '0;
                        r_we       <= w_store;
                        r_addr     <= {M_addr[31:2], 2'b00};
                        r_be       <= w_store ? w_be : 4'b0000;
                        r_wdata    <= w_wdata;
                        r_fmt.size <= M_size;
                        r_fmt.sgn  <= M_ld_signed;
                        r_fmt.lo   <= M_addr[1:0];
                        r_tmo      <= 1'b0;
                    end
                end
                ST_BUSY: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (bus_ready) begin
                        r_rdata <= bus_rdata;
                        r_state <= ST_DONE;
                    end else if (w_last) begin
                        r_tmo   <= 1'b1;
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (!M_hold) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    m_lsu_ext u_ext (
        .i_rdata  (r_rdata),
        .i_size   (r_fmt.size),
        .i_signed (r_fmt.sgn),
        .i_lo     (r_fmt.lo),
        .o_data   (M_DMRD)
    );

    assign bus_req     = (r_state == ST_BUSY);
    assign bus_we      = r_we;
    assign bus_addr    = r_addr;
    assign bus_be      = r_be;
    assign bus_wdata   = r_wdata;
    assign M_lsu_stall = w_issue | (r_state == ST_BUSY);
    assign M_exc       = w_exc_idle | w_exc_done;
    assign M_exc_code  = w_exc_idle ? (w_store ? EXC_ADES : EXC_ADEL)
                       : w_exc_done ? (r_we ? EXC_ADES : EXC_ADEL)
                       : EXC_NONE;

endmodule

// File: tb/tb_m_lsu.sv
// tb/tb_m_lsu.sv - self-checking bench for m_lsu
module tb_m_lsu;

    localparam int TIMEOUT = 16;

    logic        clk;
    logic        reset;
    logic        M_ld, M_st, M_ld_signed, M_flush, M_hold;
    logic [1:0]  M_size;
    logic [31:0] M_addr, M_wdata;
    logic        bus_req, bus_we, bus_ready;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic [3:0]  bus_be;
    logic [31:0] M_DMRD;
    logic        M_lsu_stall, M_exc;
    logic [4:0]  M_exc_code;

    logic [31:0] e_rdata, e_out;
    logic [1:0]  e_size, e_lo;
    logic        e_sgn;

    int pass_cnt  = 0;
    int total_cnt = 0;

    m_lsu dut (
        .clk         (clk),
        .reset       (reset),
        .M_ld        (M_ld),
        .M_st        (M_st),
        .M_size      (M_size),
        .M_ld_signed (M_ld_signed),
        .M_addr      (M_addr),
        .M_wdata     (M_wdata),
        .M_flush     (M_flush),
        .M_hold      (M_hold),
        .bus_req     (bus_req),
        .bus_we      (bus_we),
        .bus_addr    (bus_addr),
        .bus_be      (bus_be),
        .bus_wdata   (bus_wdata),
        .bus_ready   (bus_ready),
        .bus_rdata   (bus_rdata),
        .M_DMRD      (M_DMRD),
        .M_lsu_stall (M_lsu_stall),
        .M_exc       (M_exc),
        .M_exc_code  (M_exc_code)
    );

    m_lsu_ext u_ext (
        .i_rdata  (e_rdata),
        .i_size   (e_size),
        .i_signed (e_sgn),
        .i_lo     (e_lo),
        .o_data   (e_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    function automatic logic model_fault(input logic [1:0] size, input logic [31:0] addr, input logic store);
        int  align;
        logic in_dm, in_io;
        align = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        in_dm = addr <= 32'h2FFF;
        in_io = (addr >= 32'h7F00) && (addr <= 32'h7F23);
        return ((addr % align) != 0) || !(in_dm || in_io) || (in_io && size != 2'd2)
            || (store && (addr == 32'h7F08 || addr == 32'h7F18));
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] rdata, input logic [1:0] size,
                                               input logic sgn, input logic [1:0] lo);
        logic [31:0] v;
        v = rdata >> (8 * lo);
        if (size == 2'd0) begin
            v = v & 32'hFF;
            if (sgn && v >= 32'd128) v = v - 32'd256;
        end else if (size == 2'd1) begin
            v = v & 32'hFFFF;
            if (sgn && v >= 32'd32768) v = v - 32'd65536;
        end else begin
            v = rdata;
        end
        return v;
    endfunction

    // One complete instruction in M; starts and ends just after a rising edge with the DUT idle
    task automatic do_access(input logic ld, input logic st, input logic [1:0] size, input logic sgn,
                             input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] rdata,
                             input int delay, input int hold_n, input logic rnd_flush, output int stall_n);
        logic        store, exp_exc, tmo;
        logic [4:0]  exp_code;
        logic [3:0]  ebe;
        logic [31:0] ewd, eld;
        store    = st & !ld;
        exp_exc  = (ld | st) && model_fault(size, addr, store);
        exp_code = exp_exc ? (store ? 5'd5 : 5'd4) : 5'd0;
        stall_n  = 0;
        M_ld = ld; M_st = st; M_size = size; M_ld_signed = sgn; M_addr = addr; M_wdata = wdata;
        M_flush = 1'b0; M_hold = 1'b0; bus_ready = 1'b0;
        @(negedge clk);
        chk("idle_exc", M_exc, exp_exc);
        chk("idle_code", M_exc_code, exp_code);
        chk("idle_req", bus_req, 0);
        if (M_lsu_stall) stall_n++;
        if (exp_exc || !(ld | st)) begin
            chk("exc_stall", M_lsu_stall, 0);
            @(posedge clk); #1;
            M_ld = 1'b0; M_st = 1'b0;
            @(negedge clk);
            chk("exc_no_req", bus_req, 0);
            @(posedge clk); #1;
            return;
        end
        if (size == 2'd0) begin
            ebe = 4'b0001 << addr[1:0];
            ewd = (wdata & 32'hFF) * 32'h0101_0101;
        end else if (size == 2'd1) begin
            ebe = 4'b0011 << addr[1:0];
            ewd = (wdata & 32'hFFFF) * 32'h0001_0001;
        end else begin
            ebe = 4'b1111;
            ewd = wdata;
        end
        if (!store) ebe = 4'b0000;
        for (int n = 0; n < TIMEOUT; n++) begin
            @(posedge clk); #1;
            bus_ready = (n == delay);
            bus_rdata = (n == delay) ? rdata : $urandom;
            M_flush   = rnd_flush ? 1'($urandom_range(0, 1)) : 1'b0;
            @(negedge clk);
            if (M_lsu_stall) stall_n++;
            chk("busy_req", bus_req, 1);
            if (n == 0) begin
                chk("bus_addr", bus_addr, addr & 32'hFFFF_FFFC);
                chk("bus_we", bus_we, store);
                chk("bus_be", bus_be, ebe);
                if (store) chk("bus_wdata", bus_wdata, ewd);
            end
            if (n == delay) break;
        end
        tmo = (delay >= TIMEOUT);
        eld = model_load(rdata, size, sgn, addr[1:0]);
        @(posedge clk); #1;
        bus_ready = 1'b0;
        M_hold    = (hold_n > 0);
        M_flush   = rnd_flush ? 1'($urandom_range(0, 1)) : 1'b0;
        for (int h = 0; h <= hold_n; h++) begin
            @(negedge clk);
            if (M_lsu_stall) stall_n++;
            chk("done_req", bus_req, 0);
            chk("done_exc", M_exc, tmo);
            chk("done_code", M_exc_code, tmo ? (store ? 5'd5 : 5'd4) : 5'd0);
            if (!store && !tmo) chk("done_dmrd", M_DMRD, eld);
            @(posedge clk); #1;
            M_hold = (h + 1 < hold_n);
        end
        M_ld = 1'b0; M_st = 1'b0; M_hold = 1'b0; M_flush = 1'b0;
        @(negedge clk);
        chk("back_idle_req", bus_req, 0);
        chk("back_idle_stall", M_lsu_stall, 0);
        chk("stall_count", stall_n, 1 + (tmo ? TIMEOUT : delay + 1));
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic [31:0] rdata;
        logic [1:0]  size;
        logic        sgn;
        logic [1:0]  lo;
        logic [31:0] exp;
    } ext_vec_t;

    typedef struct {
        logic        ld;
        logic        st;
        logic [1:0]  size;
        logic [31:0] addr;
        logic        exc;
        logic [4:0]  code;
    } exc_vec_t;

    ext_vec_t xv[8];
    exc_vec_t ev[14];

    initial begin
        int          sn;
        logic        ld, sgn;
        logic [1:0]  size;
        logic [31:0] addr;
        int          pick;

        xv[0] = '{32'h80FF_FF7F, 2'd0, 1'b1, 2'd3, 32'hFFFF_FF80};
        xv[1] = '{32'h80FF_FF7F, 2'd0, 1'b0, 2'd3, 32'h0000_0080};
        xv[2] = '{32'h80FF_FF7F, 2'd0, 1'b1, 2'd0, 32'h0000_007F};
        xv[3] = '{32'h80FF_FF7F, 2'd0, 1'b1, 2'd1, 32'hFFFF_FFFF};
        xv[4] = '{32'h80FF_FF7F, 2'd1, 1'b1, 2'd2, 32'hFFFF_80FF};
        xv[5] = '{32'h80FF_FF7F, 2'd1, 1'b0, 2'd2, 32'h0000_80FF};
        xv[6] = '{32'h80FF_FF7F, 2'd1, 1'b1, 2'd0, 32'hFFFF_FF7F};
        xv[7] = '{32'h80FF_FF7F, 2'd2, 1'b1, 2'd0, 32'h80FF_FF7F};

        ev[0]  = '{1'b1, 1'b0, 2'd1, 32'h0000_0101, 1'b1, 5'd4};
        ev[1]  = '{1'b0, 1'b1, 2'd2, 32'h0000_7F08, 1'b1, 5'd5};
        ev[2]  = '{1'b1, 1'b0, 2'd2, 32'h0000_7F08, 1'b0, 5'd0};
        ev[3]  = '{1'b0, 1'b1, 2'd2, 32'h0000_7F18, 1'b1, 5'd5};
        ev[4]  = '{1'b0, 1'b1, 2'd2, 32'h0000_7F04, 1'b0, 5'd0};
        ev[5]  = '{1'b1, 1'b0, 2'd0, 32'h0000_7F00, 1'b1, 5'd4};
        ev[6]  = '{1'b0, 1'b1, 2'd2, 32'h0000_3000, 1'b1, 5'd5};
        ev[7]  = '{1'b1, 1'b0, 2'd2, 32'h0000_2FFC, 1'b0, 5'd0};
        ev[8]  = '{1'b1, 1'b0, 2'd0, 32'h0000_2FFF, 1'b0, 5'd0};
        ev[9]  = '{1'b1, 1'b0, 2'd2, 32'h0000_7F20, 1'b0, 5'd0};
        ev[10] = '{1'b1, 1'b0, 2'd2, 32'h0000_7F24, 1'b1, 5'd4};
        ev[11] = '{1'b0, 1'b1, 2'd1, 32'h0000_0102, 1'b0, 5'd0};
        ev[12] = '{1'b0, 1'b1, 2'd2, 32'h0000_0102, 1'b1, 5'd5};
        ev[13] = '{1'b0, 1'b0, 2'd2, 32'h0000_0101, 1'b0, 5'd0};

        reset = 1'b1;
        M_ld = 1'b0; M_st = 1'b0; M_size = 2'd0; M_ld_signed = 1'b0;
        M_addr = '0; M_wdata = '0; M_flush = 1'b0; M_hold = 1'b0;
        bus_ready = 1'b0; bus_rdata = '0;
        e_rdata = '0; e_size = '0; e_sgn = 1'b0; e_lo = '0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req", bus_req, 0);
        chk("rst_we", bus_we, 0);
        chk("rst_be", bus_be, 0);
        chk("rst_dmrd", M_DMRD, 0);
        chk("rst_stall", M_lsu_stall, 0);
        chk("rst_exc", M_exc, 0);
        @(posedge clk); #1;
        reset = 1'b0;

        for (int i = 0; i < 8; i++) begin
            e_rdata = xv[i].rdata; e_size = xv[i].size; e_sgn = xv[i].sgn; e_lo = xv[i].lo;
            #1;
            chk("ext_table", e_out, xv[i].exp);
        end

        // Address-rule table, with M_flush held so nothing issues
        M_flush = 1'b1;
        for (int i = 0; i < 14; i++) begin
            M_ld = ev[i].ld; M_st = ev[i].st; M_size = ev[i].size; M_addr = ev[i].addr;
            @(negedge clk);
            chk("exc_table", M_exc, ev[i].exc);
            chk("exc_table_code", M_exc_code, ev[i].code);
            chk("exc_table_req", bus_req, 0);
            @(posedge clk); #1;
        end
        M_ld = 1'b0; M_st = 1'b0; M_flush = 1'b0;
        @(posedge clk); #1;

        do_access(1'b0, 1'b1, 2'd2, 1'b0, 32'h100, 32'h1234_5678, 32'h0, 2, 0, 1'b0, sn);
        chk("sw_stall_cycles", sn, 4);
        do_access(1'b0, 1'b1, 2'd0, 1'b0, 32'h103, 32'h0000_00AB, 32'h0, 0, 0, 1'b0, sn);
        do_access(1'b1, 1'b0, 2'd0, 1'b1, 32'h103, 32'h0, 32'h80FF_FF7F, 1, 1, 1'b0, sn);
        do_access(1'b1, 1'b0, 2'd0, 1'b0, 32'h103, 32'h0, 32'h80FF_FF7F, 0, 0, 1'b0, sn);
        chk("lb_min_latency", sn, 2);
        do_access(1'b1, 1'b0, 2'd1, 1'b1, 32'h101, 32'h0, 32'h0, 0, 0, 1'b0, sn);
        do_access(1'b0, 1'b1, 2'd2, 1'b0, 32'h7F08, 32'h5, 32'h0, 0, 0, 1'b0, sn);
        do_access(1'b1, 1'b0, 2'd2, 1'b0, 32'h200, 32'h0, 32'hDEAD_BEEF, 40, 2, 1'b1, sn);
        do_access(1'b0, 1'b1, 2'd1, 1'b0, 32'h7F20, 32'h1, 32'h0, 40, 0, 1'b0, sn);

        // Flush in IDLE must keep the request from issuing
        M_ld = 1'b1; M_size = 2'd2; M_addr = 32'h200; M_flush = 1'b1;
        @(negedge clk);
        chk("flush_idle_req", bus_req, 0);
        @(posedge clk); #1;
        M_ld = 1'b0; M_flush = 1'b0;
        @(negedge clk);
        chk("flush_no_issue", bus_req, 0);
        chk("flush_no_stall", M_lsu_stall, 0);
        @(posedge clk); #1;

        // Reset while BUSY: request drops after the next edge, nothing reported
        M_ld = 1'b1; M_st = 1'b0; M_size = 2'd2; M_addr = 32'h204;
        @(negedge clk);
        chk("rb_idle_stall", M_lsu_stall, 1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rb_busy_req", bus_req, 1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        chk("rb_req_before_edge", bus_req, 1);
        @(posedge clk); #1;
        reset = 1'b0; M_ld = 1'b0;
        @(negedge clk);
        chk("rb_req_dropped", bus_req, 0);
        chk("rb_no_exc", M_exc, 0);
        chk("rb_no_stall", M_lsu_stall, 0);
        @(posedge clk); #1;

        for (int k = 0; k < 60; k++) begin
            ld   = 1'($urandom_range(0, 1));
            size = 2'($urandom_range(0, 2));
            sgn  = 1'($urandom_range(0, 1));
            pick = $urandom_range(0, 9);
            if (pick < 6)      addr = $urandom_range(0, 32'h2FFF);
            else if (pick < 8) addr = 32'h7F00 + $urandom_range(0, 39);
            else               addr = 32'h3000 + $urandom_range(0, 32'hFFFF);
            if ($urandom_range(0, 3) != 0) begin
                if (size == 2'd1) addr[0] = 1'b0;
                if (size == 2'd2) addr[1:0] = 2'b00;
            end
            do_access(ld, !ld, size, sgn, addr, $urandom, $urandom,
                      ($urandom_range(0, 7) == 0) ? 20 : $urandom_range(0, 4),
                      $urandom_range(0, 2), 1'b1, sn);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
